calc_port_sched: RTL
====================

Name: calc_port_sched

Overview:
- Four-requester front end that shares one calc ALU (add/sub/shift) between the calculator's ports.
- Captures each port's two-cycle command/operand transfer and queues one pending operation per port.
- Grants the ALU round-robin and routes the ALU result back to the issuing port as a one-cycle response.
- Invalid commands and ALU timeouts are answered locally, without using the ALU.

Parameters:
- NPORTS, 4, number of requester ports; the RTL supports only 4.
- DW, 32, operand and result width.
- CW, 4, command width.
- TIMEOUT, 15, cycles to wait for alu_done after issue before reporting an error.

Ports:
- c_clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cmd_in  input  NPORTS*CW  per-port command; port p uses slice p.
- data_in  input  NPORTS*DW  per-port operand bus.
- out_resp  output  NPORTS*2  per-port response code, 1-cycle pulse.
- out_data  output  NPORTS*DW  per-port result, valid only while out_resp is nonzero.
- alu_valid  output  1  one-cycle issue strobe to the ALU.
- alu_cmd  output  CW  issued command.
- alu_op1  output  DW  issued operand 1.
- alu_op2  output  DW  issued operand 2.
- alu_done  input  1  ALU result valid.
- alu_resp  input  2  ALU status: 01 ok, 10 overflow/underflow.
- alu_data  input  DW  ALU result.

Behaviour:
- Reset: all outputs 0; every port IDLE; ALU free; round-robin pointer = port 0; timeout counter 0.
  - Assertion mid-operation discards all captured and in-flight work; alu_valid drops immediately.
- Command codes: 1 add, 2 sub, 5 shift left, 6 shift right. 0 = no-op. Any other value is invalid.
- Per-port FSM, states IDLE, OP2, PEND, WAIT:
  - IDLE: nonzero cmd_in in cycle N -> latch cmd and data_in as op1, go to OP2.
  - OP2: data_in in cycle N+1 is latched as op2; cmd_in is ignored.
    - Valid cmd -> PEND.
    - Invalid cmd -> out_resp=11, out_data=0 in cycle N+2, then IDLE. The ALU is not used.
  - PEND: waits for a grant; on grant -> WAIT.
  - WAIT: waits for alu_done or timeout.
    - On either, out_resp/out_data are driven for exactly 1 cycle (registered), then IDLE.
    - The port accepts a new command from the cycle after its response pulse.
  - cmd_in on a port in OP2, PEND or WAIT is ignored: no response, no state change.
- Arbitration:
  - Runs only when the ALU is free; one operation is outstanding at most.
  - Round-robin among PEND ports, searching upward from the pointer. After granting port k, the pointer becomes (k+1) mod 4.
  - Grant cycle: alu_valid=1 for one cycle with the port's cmd/op1/op2. Minimum issue is cycle N+2.
  - Between issues, alu_cmd/op1/op2 hold their last values.
- ALU completion:
  - alu_done sampled high -> the WAIT port gets out_resp=alu_resp and out_data=alu_data in the next cycle. The ALU is then free.
  - The earliest next issue is the cycle after alu_done.
  - alu_done while no operation is outstanding (late or spurious) is ignored.
- Timeout:
  - The counter starts at issue. If alu_done is not seen within TIMEOUT cycles after alu_valid, the port gets out_resp=10, out_data=0 and the ALU is freed.
  - A later alu_done for the abandoned operation is ignored.
- Simultaneous events:
  - An invalid-command response and an ALU response on different ports may pulse in the same cycle.
  - A port's own command capture never collides with its response, because the port is not IDLE until after the pulse.
- Widths: outputs pass alu_data unchanged. No arithmetic is done in this block.

Test Plan:
- Single add on port 0 (cmd=1, op1=32'h1, op2=32'h2), ALU answering 1 cycle after issue with 01/32'h3 -> alu_valid in cycle 2 with 1/1/2; out_resp[0]=01, out_data=3 in cycle 4; other ports stay 0.
- All four ports issue cmd=1 in the same cycle -> grants in order 0,1,2,3. Then re-issue from all four after responses -> order continues 0,1,2,3 (pointer wrapped after port 3). Each gets exactly one response.
- Port 2 issues cmd=4'h3 -> out_resp=11, out_data=0 in cycle 2; alu_valid never asserts.
- ALU never returns alu_done -> out_resp=10, out_data=0 exactly TIMEOUT+1 cycles after alu_valid. A subsequent stray alu_done produces no response, and the next pending port is granted.
- Port 1 drives a new cmd while in WAIT -> ignored, only one response. A new cmd the cycle after the response is accepted.
- reset_n pulsed low while port 3 is in WAIT -> all outputs 0 at once; a later alu_done is ignored; after release a fresh cmd=2 on port 0 completes normally.

Source files
------------

// File: rtl/calc_port_sched.sv
// Four-port front end sharing one calc ALU: captures each port's two-cycle
// command/operand transfer, grants the ALU round-robin and routes results back.
module calc_port_sched #(
   parameter int NPORTS  = 4,
   parameter int DW      = 32,
   parameter int CW      = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                 c_clk,
   input  logic                 reset_n,
   input  logic [NPORTS*CW-1:0] cmd_in,
   input  logic [NPORTS*DW-1:0] data_in,
   output logic [NPORTS*2-1:0]  out_resp,
   output logic [NPORTS*DW-1:0] out_data,
   output logic                 alu_valid,
   output logic [CW-1:0]        alu_cmd,
   output logic [DW-1:0]        alu_op1,
   output logic [DW-1:0]        alu_op2,
   input  logic                 alu_done,
   input  logic [1:0]           alu_resp,
   input  logic [DW-1:0]        alu_data
);

   localparam int TW = $clog2(TIMEOUT + 1);

   // Handshake: alu_valid is a one-cycle issue strobe; alu_done is honoured
   // only while an operation is outstanding, otherwise it is dropped.
   typedef enum logic [1:0] {IDLE = 2'd0, OP2 = 2'd1, PEND = 2'd2, WAIT = 2'd3} state_t;

   state_t          st_q    [NPORTS];
   state_t          st_d    [NPORTS];
   logic [CW-1:0]   cmd_q   [NPORTS];
   logic [DW-1:0]   op1_q   [NPORTS];
   logic [DW-1:0]   op2_q   [NPORTS];
   logic            pulse_q [NPORTS];
   logic            pulse_d [NPORTS];
   logic [1:0]      resp_d  [NPORTS];
   logic [DW-1:0]   rdata_d [NPORTS];
   logic            elig    [NPORTS];

   logic            busy_q;
   logic [1:0]      owner_q;
   logic [1:0]      ptr_q;
   logic [TW-1:0]   cnt_q;

   logic            done_take;
   logic            tmo_hit;
   logic            can_issue;
   logic            grant_hit;
   logic [1:0]      grant_idx;
   logic [1:0]      scan_idx;
   logic            issue;
   logic [CW-1:0]   issue_cmd;
   logic [DW-1:0]   issue_op1;
   logic [DW-1:0]   issue_op2;

   function automatic logic cmd_ok(input logic [CW-1:0] c);
      return (c == CW'(1)) || (c == CW'(2)) || (c == CW'(5)) || (c == CW'(6));
   endfunction

   always_comb begin
      done_take = busy_q & alu_done;
      tmo_hit   = busy_q & ~alu_done & (cnt_q == TW'(TIMEOUT));
      can_issue = ~busy_q | done_take | tmo_hit;

      // A port still in OP2 with a valid command competes already, so the
      // issue can land in the cycle right after the operand-2 transfer.
      for (int p = 0; p < NPORTS; p++)
         elig[p] = (st_q[p] == PEND) | ((st_q[p] == OP2) & cmd_ok(cmd_q[p]));

      grant_hit = 1'b0;
      grant_idx = ptr_q;
      scan_idx  = ptr_q;
      for (int i = 0; i < NPORTS; i++) begin
         scan_idx = ptr_q + 2'(i);
         if (!grant_hit && elig[scan_idx]) begin
            grant_hit = 1'b1;
            grant_idx = scan_idx;
         end
      end
      issue = can_issue & grant_hit;

      issue_cmd = '0;
      issue_op1 = '0;
      issue_op2 = '0;
      for (int p = 0; p < NPORTS; p++) begin
         if (grant_idx == 2'(p)) begin
            issue_cmd = cmd_q[p];
            issue_op1 = op1_q[p];
            issue_op2 = (st_q[p] == OP2) ? data_in[p*DW +: DW] : op2_q[p];
         end
      end

      for (int p = 0; p < NPORTS; p++) begin
         st_d[p]    = st_q[p];
         pulse_d[p] = 1'b0;
         resp_d[p]  = 2'b00;
         rdata_d[p] = '0;
         case (st_q[p])
            IDLE: if (cmd_in[p*CW +: CW] != '0) st_d[p] = OP2;
            OP2: begin
               if (!cmd_ok(cmd_q[p])) begin
                  st_d[p]    = WAIT;
                  pulse_d[p] = 1'b1;
                  resp_d[p]  = 2'b11;
               end else if (issue && grant_idx == 2'(p)) begin
                  st_d[p] = WAIT;
               end else begin
                  st_d[p] = PEND;
               end
            end
            PEND: if (issue && grant_idx == 2'(p)) st_d[p] = WAIT;
            WAIT: begin
               // WAIT also covers the response-pulse cycle; IDLE follows it.
               if (pulse_q[p]) begin
                  st_d[p] = IDLE;
               end else if (owner_q == 2'(p) && done_take) begin
                  pulse_d[p] = 1'b1;
                  resp_d[p]  = alu_resp;
                  rdata_d[p] = alu_data;
               end else if (owner_q == 2'(p) && tmo_hit) begin
                  pulse_d[p] = 1'b1;
                  resp_d[p]  = 2'b10;
               end
            end
            default: st_d[p] = IDLE;
         endcase
      end
   end

   always_ff @(posedge c_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < NPORTS; p++) begin
            st_q[p]    <= IDLE;
            cmd_q[p]   <= '0;
            op1_q[p]   <= '0;
            op2_q[p]   <= '0;
            pulse_q[p] <= 1'b0;
         end
         out_resp  <= '0;
         out_data  <= '0;
         alu_valid <= 1'b0;
         alu_cmd   <= '0;
         alu_op1   <= '0;
         alu_op2   <= '0;
         busy_q    <= 1'b0;
         owner_q   <= 2'd0;
         ptr_q     <= 2'd0;
         cnt_q     <= '0;
      end else begin
         for (int p = 0; p < NPORTS; p++) begin
            st_q[p]    <= st_d[p];
            pulse_q[p] <= pulse_d[p];
            out_resp[p*2 +: 2]   <= resp_d[p];
            out_data[p*DW +: DW] <= rdata_d[p];
            if (st_q[p] == IDLE && cmd_in[p*CW +: CW] != '0) begin
               cmd_q[p] <= cmd_in[p*CW +: CW];
               op1_q[p] <= data_in[p*DW +: DW];
            end
            if (st_q[p] == OP2) op2_q[p] <= data_in[p*DW +: DW];
         end
         alu_valid <= issue;
         if (issue) begin
            alu_cmd <= issue_cmd;
            alu_op1 <= issue_op1;
            alu_op2 <= issue_op2;
            busy_q  <= 1'b1;
            owner_q <= grant_idx;
            ptr_q   <= grant_idx + 2'd1;
            cnt_q   <= '0;
         end else if (done_take || tmo_hit) begin
            busy_q <= 1'b0;
         end else if (busy_q) begin
            cnt_q <= cnt_q + TW'(1);
         end
      end
   end

endmodule
